// File: rtl/branch_predictor_gshare.sv
// Fetch-stage direction/target predictor: gshare- or bimodal-indexed counter table
// plus tagged BTB, with speculative history repair, post-reset clear sweep and perf counters.
module branch_predictor_gshare #(
  parameter int PC_WIDTH   = 32,
  parameter int IDX_BITS   = 6,
  parameter int TAG_WIDTH  = 8,
  parameter int CTR_WIDTH  = 2,
  parameter int HIST_LEN   = 6,
  parameter int PERF_WIDTH = 32,
  localparam int HL        = (HIST_LEN > 0) ? HIST_LEN : 1
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   F_PC_i,
  input  logic                  F_valid_i,
  output logic                  pred_hit_o,
  output logic                  pred_taken_o,
  output logic [PC_WIDTH-1:0]   pred_target_o,
  output logic [HL-1:0]         pred_hist_o,
  input  logic                  train_valid_i,
  input  logic [PC_WIDTH-1:0]   train_pc_i,
  input  logic                  train_taken_i,
  input  logic [PC_WIDTH-1:0]   train_target_i,
  input  logic                  train_predict_i,
  input  logic [HL-1:0]         train_hist_i,
  output logic                  mispredict_o,
  output logic                  init_busy_o,
  output logic [PERF_WIDTH-1:0] perf_branch_o,
  output logic [PERF_WIDTH-1:0] perf_mispred_o
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT =
    CTR_WIDTH'((2 ** (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q;
  logic [HL-1:0] ghr_q, ghr_d;
  logic [HL-1:0] ghr_rep, ghr_spec;
  logic run;

  logic                 btb_valid [DEPTH];
  logic [TAG_WIDTH-1:0] btb_tag   [DEPTH];
  logic [PC_WIDTH-1:0]  btb_tgt   [DEPTH];
  logic [CTR_WIDTH-1:0] ctr       [DEPTH];

  logic [IDX_BITS-1:0]  f_bidx, f_cidx, f_hx;
  logic [TAG_WIDTH-1:0] f_tag;
  logic                 f_hit;
  logic [IDX_BITS-1:0]  t_bidx, t_cidx, t_hx;
  logic [TAG_WIDTH-1:0] t_tag;
  logic [CTR_WIDTH-1:0] t_ctr_old, t_ctr_new;
  logic                 train_en;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) ptr_q <= ptr_q + IDX_BITS'(1);
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (ptr_q == '1) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    init_busy_o = 1'b1;
    unique case (state_q)
      S_INIT:  init_busy_o = 1'b1;
      S_RUN:   init_busy_o = 1'b0;
      default: init_busy_o = 1'b1;
    endcase
  end

  assign run = !init_busy_o;

  generate
    if (HIST_LEN == 0) begin : g_bimodal
      assign f_hx     = '0;
      assign t_hx     = '0;
      assign ghr_rep  = '0;
      assign ghr_spec = '0;
    end else if (HIST_LEN == 1) begin : g_hist1
      assign f_hx     = IDX_BITS'(ghr_q);
      assign t_hx     = IDX_BITS'(train_hist_i);
      assign ghr_rep  = train_taken_i;
      assign ghr_spec = pred_taken_o;
    end else begin : g_histn
      assign f_hx     = IDX_BITS'(ghr_q);
      assign t_hx     = IDX_BITS'(train_hist_i);
      assign ghr_rep  = {train_hist_i[HL-2:0], train_taken_i};
      assign ghr_spec = {ghr_q[HL-2:0], pred_taken_o};
    end
  endgenerate

  assign f_bidx = F_PC_i[IDX_BITS+1:2];
  assign f_tag  = F_PC_i[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2];
  assign f_cidx = f_bidx ^ f_hx;
  assign f_hit  = btb_valid[f_bidx] && (btb_tag[f_bidx] == f_tag);

  assign pred_hit_o    = run && f_hit;
  assign pred_taken_o  = pred_hit_o && ctr[f_cidx][CTR_WIDTH-1];
  assign pred_target_o = pred_hit_o ? btb_tgt[f_bidx] : '0;
  assign pred_hist_o   = run ? ghr_q : '0;

  assign t_bidx    = train_pc_i[IDX_BITS+1:2];
  assign t_tag     = train_pc_i[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2];
  assign t_cidx    = t_bidx ^ t_hx;
  assign t_ctr_old = ctr[t_cidx];
  assign train_en  = run && train_valid_i;

  assign mispredict_o = train_valid_i && (train_taken_i != train_predict_i);

  always_comb begin
    t_ctr_new = t_ctr_old;
    if (train_taken_i) begin
      if (t_ctr_old != CTR_MAX) t_ctr_new = t_ctr_old + CTR_WIDTH'(1);
    end else begin
      if (t_ctr_old != '0) t_ctr_new = t_ctr_old - CTR_WIDTH'(1);
    end
  end

  // Tables carry no reset; the INIT sweep clears them instead
  always_ff @(posedge clk_i) begin
    if (!run) begin
      btb_valid[ptr_q] <= 1'b0;
      ctr[ptr_q]       <= CTR_INIT;
    end else if (train_valid_i) begin
      ctr[t_cidx] <= t_ctr_new;
      if (train_taken_i) begin
        btb_valid[t_bidx] <= 1'b1;
        btb_tag[t_bidx]   <= t_tag;
        btb_tgt[t_bidx]   <= train_target_i;
      end
    end
  end

  // Repair from the resolved branch beats speculative fetch update
  always_comb begin
    ghr_d = ghr_q;
    if (run) begin
      if (mispredict_o)                 ghr_d = ghr_rep;
      else if (F_valid_i && pred_hit_o) ghr_d = ghr_spec;
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      perf_branch_o  <= '0;
      perf_mispred_o <= '0;
    end else if (train_en) begin
      if (perf_branch_o != '1)
        perf_branch_o <= perf_branch_o + PERF_WIDTH'(1);
      if (mispredict_o && perf_mispred_o != '1)
        perf_mispred_o <= perf_mispred_o + PERF_WIDTH'(1);
    end
  end

endmodule
